// File: rtl/clct_busy_marker_cclut.sv
// Busy-window generator for the 1-of-7 ccLUT best-pattern sorter: after a first CLCT,
// blanks key half-strips around its key for dead_time clocks so the second search skips them.
module clct_busy_marker_cclut #(
   parameter int MXKEYBX   = 8,
   parameter int MXHS      = 224,
   parameter int GRPHS     = 32,
   parameter int BUSY_SPAN = 15,
   parameter int SPLIT_KEY = 128
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clct_vld,
   input  logic [MXKEYBX-1:0] clct_key,
   input  logic [3:0]         dead_time,
   input  logic               flush,
   output logic [MXHS-1:0]    busy_key,
   output logic [6:0]         bsy_grp,
   output logic               busy_active,
   output logic [MXKEYBX-1:0] held_key
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [MXKEYBX-1:0]   key_q, key_d;
   logic [MXHS-1:0]      busy_key_q, busy_key_d;
   logic [6:0]           bsy_grp_q, bsy_grp_d;
   logic                 busy_active_q, busy_active_d;
   logic [MXKEYBX-1:0]   held_key_q, held_key_d;
   logic                 event_vld;

   // Clipped window around key; signed int math so neither end can wrap.
   function automatic logic [MXHS-1:0] window(input logic [MXKEYBX-1:0] key);
      int k;
      int lo;
      int hi;
      logic [MXHS-1:0] w;
      k  = int'(key);
      lo = k - BUSY_SPAN;
      hi = k + BUSY_SPAN;
      if (lo < 0) lo = 0;
      if (hi > MXHS - 1) hi = MXHS - 1;
      if (SPLIT_KEY != 0) begin
         if (k < SPLIT_KEY) begin
            if (hi > SPLIT_KEY - 1) hi = SPLIT_KEY - 1;
         end else if (lo < SPLIT_KEY) begin
            lo = SPLIT_KEY;
         end
      end
      for (int i = 0; i < MXHS; i++) w[i] = (i >= lo) && (i <= hi);
      return w;
   endfunction

   assign event_vld = clct_vld && (int'(clct_key) < MXHS) && (dead_time != 4'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         key_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (event_vld) begin
                  state_d = HOLD;
                  cnt_d   = dead_time;
                  key_d   = clct_key;
               end
            end
            HOLD: begin
               if (event_vld) begin
                  cnt_d = dead_time;
                  key_d = clct_key;
               end else if (cnt_q == 4'd1) begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
                  key_d   = '0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output stage: mask and group flags come from the same registered cycle.
   always_comb begin
      busy_active_d = !flush && (state_q == HOLD);
      busy_key_d    = busy_active_d ? window(key_q) : '0;
      held_key_d    = busy_active_d ? key_q : '0;
      bsy_grp_d     = '0;
      for (int g = 0; g < 7; g++) bsy_grp_d[g] = &busy_key_d[g*GRPHS +: GRPHS];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         key_q         <= '0;
         busy_key_q    <= '0;
         bsy_grp_q     <= '0;
         busy_active_q <= 1'b0;
         held_key_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         key_q         <= key_d;
         busy_key_q    <= busy_key_d;
         bsy_grp_q     <= bsy_grp_d;
         busy_active_q <= busy_active_d;
         held_key_q    <= held_key_d;
      end
   end

   assign busy_key    = busy_key_q;
   assign bsy_grp     = bsy_grp_q;
   assign busy_active = busy_active_q;
   assign held_key    = held_key_q;

endmodule

// File: tb/tb_clct_busy_marker_cclut.sv
// Bench for clct_busy_marker_cclut: two instances (span 15 and 31) checked against a
// per-cycle schedule of which key owns the outputs on each clock.
module tb_clct_busy_marker_cclut;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         clct_vld = 1'b0;
   logic [7:0]   clct_key = 8'd0;
   logic [3:0]   dead_time = 4'd0;
   logic         flush = 1'b0;

   logic [223:0] busy_key_a, busy_key_b;
   logic [6:0]   bsy_grp_a, bsy_grp_b;
   logic         busy_active_a, busy_active_b;
   logic [7:0]   held_key_a, held_key_b;
   logic [239:0] out_a, out_b, exp_a, exp_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int sched [int];

   typedef struct {logic v; int k; int dt; logic f;} stim_t;

   always #5 clock = ~clock;

   clct_busy_marker_cclut #(.BUSY_SPAN(15)) dut_a (
      .clock(clock), .reset_n(reset_n), .clct_vld(clct_vld), .clct_key(clct_key),
      .dead_time(dead_time), .flush(flush), .busy_key(busy_key_a), .bsy_grp(bsy_grp_a),
      .busy_active(busy_active_a), .held_key(held_key_a));

   clct_busy_marker_cclut #(.BUSY_SPAN(31)) dut_b (
      .clock(clock), .reset_n(reset_n), .clct_vld(clct_vld), .clct_key(clct_key),
      .dead_time(dead_time), .flush(flush), .busy_key(busy_key_b), .bsy_grp(bsy_grp_b),
      .busy_active(busy_active_b), .held_key(held_key_b));

   assign out_a = {busy_key_a, bsy_grp_a, busy_active_a, held_key_a};
   assign out_b = {busy_key_b, bsy_grp_b, busy_active_b, held_key_b};

   // Expected packed outputs for the key owning this cycle (-1 = nobody).
   function automatic logic [239:0] model_out(input int key, input int span);
      logic [239:0] r;
      int lo, hi;
      r = '0;
      if (key < 0) return r;
      lo = key - span;
      hi = key + span;
      if (lo < 0) lo = 0;
      if (hi > 223) hi = 223;
      if (key < 128 && hi > 127) hi = 127;
      if (key >= 128 && lo < 128) lo = 128;
      for (int i = 0; i < 224; i++) if (i >= lo && i <= hi) r[16+i] = 1'b1;
      for (int g = 0; g < 7; g++) if (lo <= 32*g && hi >= 32*g + 31) r[9+g] = 1'b1;
      r[8] = 1'b1;
      r[7:0] = key[7:0];
      return r;
   endfunction

   task automatic tick(input logic v, input int k, input int dt, input logic f);
      int owner;
      clct_vld  = v;
      clct_key  = k[7:0];
      dead_time = dt[3:0];
      flush     = f;
      @(posedge clock);
      cyc++;
      sched.delete(cyc - 1);
      if (f) begin
         for (int t = cyc; t <= cyc + 16; t++) sched.delete(t);
      end else if (v && k < 224 && dt != 0) begin
         for (int t = cyc + 1; t <= cyc + 16; t++) sched.delete(t);
         for (int t = cyc + 1; t <= cyc + dt; t++) sched[t] = k;
      end
      #1;
      owner = sched.exists(cyc) ? sched[cyc] : -1;
      exp_a = model_out(owner, 15);
      exp_b = model_out(owner, 31);
      clct_vld = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      cyc += 3;
      sched.delete();
      #1;
      checks += 2;
      if (out_a !== 240'd0) begin errors++; $display("FAIL reset_a got=%h exp=0", out_a); end
      if (out_b !== 240'd0) begin errors++; $display("FAIL reset_b got=%h exp=0", out_b); end
      #2 reset_n = 1'b1;
      repeat (2) begin
         tick(1'b0, 0, 0, 1'b0);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL post_reset_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL post_reset_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
      end
   endtask

   task automatic test_basic();
      stim_t q[$];
      q.push_back('{1'b1, 50, 4, 1'b0});
      repeat (6) q.push_back('{1'b0, 0, 0, 1'b0});
      foreach (q[s]) begin
         tick(q[s].v, q[s].k, q[s].dt, q[s].f);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL basic_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL basic_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
         if (s == 1) begin
            checks++;
            if (held_key_a !== 8'd50) begin errors++; $display("FAIL basic_held got=%0d exp=50", held_key_a); end
         end
      end
   endtask

   task automatic test_edge_clip();
      stim_t q[$];
      int keys[4] = '{3, 220, 130, 127};
      foreach (keys[j]) begin
         q.push_back('{1'b1, keys[j], 2, 1'b0});
         repeat (3) q.push_back('{1'b0, 0, 0, 1'b0});
      end
      foreach (q[s]) begin
         tick(q[s].v, q[s].k, q[s].dt, q[s].f);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL clip_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL clip_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
      end
   endtask

   task automatic test_retrigger();
      stim_t q[$];
      q.push_back('{1'b1, 40, 5, 1'b0});
      q.push_back('{1'b0, 0, 9, 1'b0});
      q.push_back('{1'b1, 100, 2, 1'b0});
      repeat (4) q.push_back('{1'b0, 0, 0, 1'b0});
      foreach (q[s]) begin
         tick(q[s].v, q[s].k, q[s].dt, q[s].f);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL retrig_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL retrig_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
      end
   endtask

   task automatic test_flush_ignore();
      stim_t q[$];
      q.push_back('{1'b1, 60, 6, 1'b0});
      q.push_back('{1'b0, 0, 0, 1'b0});
      q.push_back('{1'b1, 90, 3, 1'b1});
      repeat (2) q.push_back('{1'b0, 0, 0, 1'b0});
      q.push_back('{1'b1, 224, 5, 1'b0});
      q.push_back('{1'b1, 10, 0, 1'b0});
      q.push_back('{1'b0, 0, 0, 1'b0});
      q.push_back('{1'b1, 70, 5, 1'b0});
      q.push_back('{1'b1, 224, 3, 1'b0});
      q.push_back('{1'b1, 150, 0, 1'b0});
      q.push_back('{1'b0, 0, 1, 1'b0});
      repeat (4) q.push_back('{1'b0, 0, 0, 1'b0});
      foreach (q[s]) begin
         tick(q[s].v, q[s].k, q[s].dt, q[s].f);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL flush_ign_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL flush_ign_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
      end
   endtask

   task automatic test_group();
      stim_t q[$];
      q.push_back('{1'b1, 79, 1, 1'b0});
      repeat (3) q.push_back('{1'b0, 0, 0, 1'b0});
      foreach (q[s]) begin
         tick(q[s].v, q[s].k, q[s].dt, q[s].f);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL group_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL group_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
         if (s == 1) begin
            checks++;
            if (bsy_grp_b !== 7'b0000100) begin errors++; $display("FAIL group_flag got=%b exp=0000100", bsy_grp_b); end
         end
         if (s == 2) begin
            checks++;
            if (bsy_grp_b !== 7'b0000000) begin errors++; $display("FAIL group_single got=%b exp=0000000", bsy_grp_b); end
         end
      end
   endtask

   task automatic test_async_reset();
      tick(1'b1, 50, 8, 1'b0);
      repeat (2) begin
         tick(1'b0, 0, 0, 1'b0);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL pre_async_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL pre_async_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
      end
      #2 reset_n = 1'b0;
      #1;
      checks += 2;
      if (out_a !== 240'd0) begin errors++; $display("FAIL async_reset_a got=%h exp=0", out_a); end
      if (out_b !== 240'd0) begin errors++; $display("FAIL async_reset_b got=%h exp=0", out_b); end
      sched.delete();
      @(posedge clock);
      cyc++;
      #3 reset_n = 1'b1;
      repeat (3) begin
         tick(1'b0, 0, 0, 1'b0);
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL post_async_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL post_async_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 400; s++) begin
         tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, 239)),
              int'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
         checks += 2;
         if (out_a !== exp_a) begin errors++; $display("FAIL random_a cyc=%0d got=%h exp=%h", cyc, out_a, exp_a); end
         if (out_b !== exp_b) begin errors++; $display("FAIL random_b cyc=%0d got=%h exp=%h", cyc, out_b, exp_b); end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_edge_clip();
      test_retrigger();
      test_flush_ignore();
      test_group();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
